// File: rtl/sparse_aer_serdes_pkg.sv
// Shared types for the sparse address-event serializer/deserializer:
// opcode encoding, TX/RX state encodings and the frame length helper.
package sparse_aer_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_SET      = 3'd1,
    OP_CLR      = 3'd2,
    OP_LOAD     = 3'd3,
    OP_START    = 3'd4,
    OP_ABORT    = 3'd5,
    OP_RX_CLEAR = 3'd6,
    OP_RSVD     = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_ADDR  = 2'd2,
    T_DONE  = 2'd3
  } tx_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ADDR = 1'b1
  } rx_state_t;

  // One start bit followed by the binary address.
  function automatic int frame_len(input int addr_w);
    return 1 + addr_w;
  endfunction

endpackage

// File: rtl/sparse_aer_serdes_if.sv
// Control, serial-line and receive-side signals of the sparse AER SerDes.
interface sparse_aer_serdes_if #(parameter int SIZE = 8);
  localparam int ADDR_W = $clog2(SIZE);

  logic              enable;
  logic [2:0]        instruction;
  logic [ADDR_W-1:0] addr_in;
  logic [SIZE-1:0]   vec_in;
  logic              bitstream_out;
  logic              tx_busy;
  logic              tx_done;
  logic              bitstream_in;
  logic [ADDR_W-1:0] rx_addr;
  logic              rx_valid;
  logic              rx_err;
  logic [SIZE-1:0]   rx_vec;

  modport master (
    output enable, instruction, addr_in, vec_in, bitstream_in,
    input  bitstream_out, tx_busy, tx_done, rx_addr, rx_valid, rx_err, rx_vec
  );

  modport slave (
    input  enable, instruction, addr_in, vec_in, bitstream_in,
    output bitstream_out, tx_busy, tx_done, rx_addr, rx_valid, rx_err, rx_vec
  );
endinterface

// File: rtl/sparse_aer_serdes_prio_enc.sv
// Lowest-index-first priority encoder: one-hot grant, binary index, any-set.
module sparse_prio_enc
  import sparse_aer_pkg::*;
#(
  parameter int SIZE = 8,
  localparam int ADDR_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]   req,
  output logic [SIZE-1:0]   grant,
  output logic [ADDR_W-1:0] idx,
  output logic              any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = ADDR_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparse_aer_serdes.sv
// Sparse address-event SerDes: TX streams each pending event as a framed
// address (start bit, address MSB first, lowest index first); RX decodes the
// same framing into an address stream and an accumulated event vector.
module sparse_aer_serdes
  import sparse_aer_pkg::*;
#(
  parameter int SIZE = 8
) (
  input logic              clk,
  input logic              rst_n,
  sparse_aer_serdes_if.slave bus
);
  localparam int ADDR_W = $clog2(SIZE);

  op_t               op;
  tx_state_t         tx_state, tx_state_n;
  rx_state_t         rx_state, rx_state_n;
  logic [SIZE-1:0]   pending, pending_n, set_mask, clr_mask, grant;
  logic [ADDR_W-1:0] grant_idx, tx_shift, tx_shift_n, tx_cnt, tx_cnt_n;
  logic              grant_any, take_grant;
  logic              bout, bout_n, busy, busy_n, done, done_n;
  logic [ADDR_W-1:0] rx_shift, rx_shift_n, rx_cnt, rx_cnt_n, rx_word;
  logic [ADDR_W-1:0] rx_addr, rx_addr_n;
  logic              rx_valid, rx_valid_n, rx_err, rx_err_n;
  logic [SIZE-1:0]   rx_vec, rx_vec_n, rx_set;

  assign op = op_t'(bus.instruction);

  sparse_prio_enc #(.SIZE(SIZE)) u_prio (
    .req   (pending),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // SET/CLR decode; out-of-range indices produce an empty mask.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (op == OP_SET && int'(bus.addr_in) < SIZE) set_mask[bus.addr_in] = 1'b1;
    if (op == OP_CLR && int'(bus.addr_in) < SIZE) clr_mask[bus.addr_in] = 1'b1;
  end

  // TX next state, serial bit and pending-vector update.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_shift_n = tx_shift;
    bout_n     = bout;
    busy_n     = busy;
    done_n     = 1'b0;
    take_grant = 1'b0;
    case (tx_state)
      T_IDLE, T_DONE: begin
        tx_state_n = T_IDLE;
        bout_n     = 1'b0;
        busy_n     = 1'b0;
        if (op == OP_START) begin
          if (grant_any) begin
            tx_state_n = T_START;
            take_grant = 1'b1;
            bout_n     = 1'b1;
            busy_n     = 1'b1;
          end else begin
            tx_state_n = T_DONE;
            done_n     = 1'b1;
          end
        end
      end
      T_START: begin
        tx_state_n = T_ADDR;
        tx_cnt_n   = ADDR_W'(ADDR_W - 1);
        bout_n     = tx_shift[ADDR_W-1];
        tx_shift_n = tx_shift << 1;
      end
      T_ADDR: begin
        if (tx_cnt != '0) begin
          tx_cnt_n   = tx_cnt - ADDR_W'(1);
          bout_n     = tx_shift[ADDR_W-1];
          tx_shift_n = tx_shift << 1;
        end else if (grant_any) begin
          tx_state_n = T_START;
          take_grant = 1'b1;
          bout_n     = 1'b1;
        end else begin
          tx_state_n = T_DONE;
          bout_n     = 1'b0;
          busy_n     = 1'b0;
          done_n     = 1'b1;
        end
      end
      default: tx_state_n = T_IDLE;
    endcase
    if (take_grant) tx_shift_n = grant_idx;

    // A SET of the bit being granted this cycle keeps it pending.
    pending_n = take_grant ? (pending & ~grant) : pending;
    pending_n = (pending_n | set_mask) & ~clr_mask;
    if (op == OP_LOAD) pending_n = bus.vec_in;
    if (op == OP_ABORT) begin
      pending_n  = '0;
      tx_state_n = T_IDLE;
      bout_n     = 1'b0;
      busy_n     = 1'b0;
      done_n     = 1'b0;
    end
  end

  // RX frame decode and event-vector accumulation.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_shift_n = rx_shift;
    rx_addr_n  = rx_addr;
    rx_valid_n = 1'b0;
    rx_err_n   = 1'b0;
    rx_set     = '0;
    rx_word    = ADDR_W'({rx_shift, bus.bitstream_in});
    case (rx_state)
      R_IDLE: begin
        if (bus.bitstream_in) begin
          rx_state_n = R_ADDR;
          rx_cnt_n   = ADDR_W'(ADDR_W - 1);
        end
      end
      R_ADDR: begin
        rx_shift_n = rx_word;
        if (rx_cnt == '0) begin
          rx_state_n = R_IDLE;
          rx_addr_n  = rx_word;
          if (int'(rx_word) < SIZE) begin
            rx_valid_n      = 1'b1;
            rx_set[rx_word] = 1'b1;
          end else begin
            rx_err_n = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt - ADDR_W'(1);
        end
      end
      default: rx_state_n = R_IDLE;
    endcase
    // A newly received event survives a same-cycle clear.
    rx_vec_n = ((op == OP_RX_CLEAR) ? '0 : rx_vec) | rx_set;
  end

  // State and output registers; enable low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_shift <= '0;
      pending  <= '0;
      bout     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_state <= R_IDLE;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_addr  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      rx_vec   <= '0;
    end else if (bus.enable) begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_shift <= tx_shift_n;
      pending  <= pending_n;
      bout     <= bout_n;
      busy     <= busy_n;
      done     <= done_n;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_shift <= rx_shift_n;
      rx_addr  <= rx_addr_n;
      rx_valid <= rx_valid_n;
      rx_err   <= rx_err_n;
      rx_vec   <= rx_vec_n;
    end
  end

  assign bus.bitstream_out = bout;
  assign bus.tx_busy       = busy;
  assign bus.tx_done       = done;
  assign bus.rx_addr       = rx_addr;
  assign bus.rx_valid      = rx_valid;
  assign bus.rx_err        = rx_err;
  assign bus.rx_vec        = rx_vec;

endmodule

// File: tb/tb_sparse_aer_serdes.sv
// Bench for sparse_aer_serdes: an 8-event instance in loopback checked every
// cycle against a frame-schedule model, plus a 6-event instance with literal
// expectations for out-of-range addresses.
module tb_sparse_aer_serdes;
  import sparse_aer_pkg::*;

  localparam int N  = 1024;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sparse_aer_serdes_if #(.SIZE(8)) bus8();
  sparse_aer_serdes_if #(.SIZE(6)) bus6();

  logic lb;
  logic rx6_in;
  assign bus8.bitstream_in = lb & bus8.bitstream_out;
  assign bus6.bitstream_in = rx6_in;

  sparse_aer_serdes #(.SIZE(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  sparse_aer_serdes #(.SIZE(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

  // Enabled-cycle counter: the model timeline advances only on enabled edges.
  int ecyc = 0;
  always @(posedge clk) if (rst_n && bus8.enable) ecyc <= ecyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic chk = 1'b0;

  logic       exp_bout [N];
  logic       exp_busy [N];
  logic       exp_done [N];
  logic       exp_valid[N];
  logic [7:0] exp_vec  [N];
  logic [2:0] exp_addr [N];
  logic [7:0] ev_set   [N];
  bit         ev_clr   [N];
  bit         ev_av    [N];
  logic [2:0] ev_a     [N];
  int         fq[$];

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Held outputs (rx_vec, rx_addr) derived by replaying receive events.
  task automatic rebuild();
    logic [7:0] v;
    logic [2:0] a;
    v = '0;
    a = '0;
    for (int i = 0; i < N; i++) begin
      if (ev_clr[i]) v = '0;
      v = v | ev_set[i];
      if (ev_av[i]) a = ev_a[i];
      exp_vec[i]  = v;
      exp_addr[i] = a;
    end
  endtask

  // START in cycle base sends the addresses in fq back to back; cut marks
  // the first cycle silenced by an ABORT.
  task automatic sched_tx(input int base, input bit lbk, input int cut);
    int f, s, a;
    f = frame_len(AW);
    for (int j = 0; j < fq.size(); j++) begin
      s = base + 1 + j * f;
      a = fq[j];
      for (int p = 0; p < f; p++) begin
        if (s + p < cut) begin
          exp_bout[s+p] = (p == 0) ? 1'b1 : 1'((a >> (AW - p)) & 1);
          exp_busy[s+p] = 1'b1;
        end
      end
      if (lbk) begin
        exp_valid[s+f] = 1'b1;
        ev_av[s+f]     = 1'b1;
        ev_a[s+f]      = 3'(a);
        ev_set[s+f]    = ev_set[s+f] | 8'(1 << a);
      end
    end
    if (base + 1 + fq.size() * f < cut) exp_done[base + 1 + fq.size() * f] = 1'b1;
    rebuild();
  endtask

  task automatic zero_from(input int e);
    for (int i = e; i < N; i++) begin
      exp_bout[i] = 1'b0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0; exp_valid[i] = 1'b0;
      ev_set[i] = '0; ev_clr[i] = 1'b0; ev_av[i] = 1'b0; ev_a[i] = '0;
    end
    ev_clr[e] = 1'b1;
    ev_av[e]  = 1'b1;
    rebuild();
  endtask

  task automatic rx_clear_at(input int e);
    ev_clr[e+1] = 1'b1;
    rebuild();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic op8(input op_t o, input logic [2:0] a, input logic [7:0] v);
    bus8.instruction = o;
    bus8.addr_in     = a;
    bus8.vec_in      = v;
    step(1);
    bus8.instruction = OP_NOP;
  endtask

  task automatic op6(input op_t o, input logic [2:0] a, input logic [5:0] v);
    bus6.instruction = o;
    bus6.addr_in     = a;
    bus6.vec_in      = v;
    step(1);
    bus6.instruction = OP_NOP;
  endtask

  initial begin
    int base, cyc;
    logic [11:0] cap;
    logic [3:0]  cap4, pat;
    bus8.enable = 1'b1; bus8.instruction = OP_NOP; bus8.addr_in = '0; bus8.vec_in = '0;
    bus6.enable = 1'b1; bus6.instruction = OP_NOP; bus6.addr_in = '0; bus6.vec_in = '0;
    lb = 1'b1;
    rx6_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_bout[i] = 1'b0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0; exp_valid[i] = 1'b0;
      ev_set[i] = '0; ev_clr[i] = 1'b0; ev_av[i] = 1'b0; ev_a[i] = '0;
    end
    rebuild();
    fork
      begin : monitor
        int e;
        forever begin
          @(negedge clk);
          if (chk && ecyc < N) begin
            e = ecyc;
            lit($sformatf("bitstream_out@%0d", e), 32'(bus8.bitstream_out), 32'(exp_bout[e]));
            lit($sformatf("tx_busy@%0d", e), 32'(bus8.tx_busy), 32'(exp_busy[e]));
            lit($sformatf("tx_done@%0d", e), 32'(bus8.tx_done), 32'(exp_done[e]));
            lit($sformatf("rx_valid@%0d", e), 32'(bus8.rx_valid), 32'(exp_valid[e]));
            lit($sformatf("rx_err@%0d", e), 32'(bus8.rx_err), 32'(1'b0));
            lit($sformatf("rx_addr@%0d", e), 32'(bus8.rx_addr), 32'(exp_addr[e]));
            lit($sformatf("rx_vec@%0d", e), 32'(bus8.rx_vec), 32'(exp_vec[e]));
          end
        end
      end
      begin : stim
        // Reset state
        #3;
        lit("rst_bout", 32'(bus8.bitstream_out), 0);
        lit("rst_busy", 32'(bus8.tx_busy), 0);
        lit("rst_vec", 32'(bus8.rx_vec), 0);
        lit("rst6_addr", 32'(bus6.rx_addr), 0);
        #9 rst_n = 1'b1;
        step(1);
        chk = 1'b1;

        // START with nothing pending
        base = ecyc; fq = {}; sched_tx(base, 1'b1, N);
        op8(OP_START, 3'd0, 8'h00);
        @(negedge clk);
        lit("empty_done", 32'(bus8.tx_done), 1);
        lit("empty_bout", 32'(bus8.bitstream_out), 0);
        step(3);

        // LOAD 1001_0010, START, loopback; a second START mid-run is ignored
        op8(OP_LOAD, 3'd0, 8'b1001_0010);
        base = ecyc; fq = {1, 4, 7}; sched_tx(base, 1'b1, N);
        op8(OP_START, 3'd0, 8'h00);
        cap = '0;
        for (int n = 1; n <= 12; n++) begin
          @(negedge clk);
          cap = {cap[10:0], bus8.bitstream_out};
          if (n == 3) bus8.instruction = OP_START;
          step(1);
          bus8.instruction = OP_NOP;
        end
        @(negedge clk);
        lit("load_bits", 32'(cap), 32'(12'b1001_1100_1111));
        lit("load_done13", 32'(bus8.tx_done), 1);
        lit("load_valid13", 32'(bus8.rx_valid), 1);
        lit("load_addr13", 32'(bus8.rx_addr), 7);
        lit("load_vec", 32'(bus8.rx_vec), 32'(8'b1001_0010));
        step(2);
        rx_clear_at(ecyc);
        op8(OP_RX_CLEAR, 3'd0, 8'h00);
        step(1);

        // Re-SET of the granted bit; RX_CLEAR coincides with the last rx set
        op8(OP_LOAD, 3'd0, 8'b0000_0011);
        base = ecyc; fq = {0, 0, 1}; sched_tx(base, 1'b1, N);
        rx_clear_at(base + 12);
        op8(OP_START, 3'd0, 8'h00);
        op8(OP_SET, 3'd0, 8'h00);
        step(10);
        op8(OP_RX_CLEAR, 3'd0, 8'h00);
        @(negedge clk);
        lit("reset_done13", 32'(bus8.tx_done), 1);
        lit("setwins_vec", 32'(bus8.rx_vec), 32'(8'b0000_0010));
        step(2);

        // Stall three cycles mid-frame
        rx_clear_at(ecyc);
        op8(OP_RX_CLEAR, 3'd0, 8'h00);
        op8(OP_LOAD, 3'd0, 8'b0110_0000);
        base = ecyc; fq = {5, 6}; sched_tx(base, 1'b1, N);
        op8(OP_START, 3'd0, 8'h00);
        step(1);
        bus8.enable = 1'b0;
        step(3);
        bus8.enable = 1'b1;
        cyc = 5;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (bus8.tx_done) break;
          step(1);
          cyc++;
        end
        lit("stall_done_cycle", 32'(cyc), 12);
        lit("stall_vec", 32'(bus8.rx_vec), 32'(8'b0110_0000));
        step(2);

        // Reset during the second frame
        rx_clear_at(ecyc);
        op8(OP_RX_CLEAR, 3'd0, 8'h00);
        op8(OP_LOAD, 3'd0, 8'b1000_0100);
        base = ecyc; fq = {2, 7}; sched_tx(base, 1'b1, N);
        op8(OP_START, 3'd0, 8'h00);
        step(5);
        @(negedge clk);
        lit("pre_rst_addr", 32'(bus8.rx_addr), 2);
        #2 rst_n = 1'b0;
        chk = 1'b0;
        #1;
        lit("arst_bout", 32'(bus8.bitstream_out), 0);
        lit("arst_busy", 32'(bus8.tx_busy), 0);
        lit("arst_addr", 32'(bus8.rx_addr), 0);
        lit("arst_vec", 32'(bus8.rx_vec), 0);
        zero_from(ecyc);
        step(1);
        #3 rst_n = 1'b1;
        step(1);
        chk = 1'b1;
        base = ecyc; fq = {}; sched_tx(base, 1'b1, N);
        op8(OP_START, 3'd0, 8'h00);
        @(negedge clk);
        lit("post_rst_done", 32'(bus8.tx_done), 1);
        step(2);

        // SET/SET/CLR leaves only address 5
        op8(OP_SET, 3'd2, 8'h00);
        op8(OP_SET, 3'd5, 8'h00);
        op8(OP_CLR, 3'd2, 8'h00);
        base = ecyc; fq = {5}; sched_tx(base, 1'b1, N);
        op8(OP_START, 3'd0, 8'h00);
        step(7);

        // ABORT mid-frame, then pending must be empty
        lb = 1'b0;
        op8(OP_LOAD, 3'd0, 8'b0000_1000);
        base = ecyc; fq = {3}; sched_tx(base, 1'b0, base + 3);
        op8(OP_START, 3'd0, 8'h00);
        step(1);
        op8(OP_ABORT, 3'd0, 8'h00);
        @(negedge clk);
        lit("abort_bout", 32'(bus8.bitstream_out), 0);
        step(6);
        base = ecyc; fq = {}; sched_tx(base, 1'b0, N);
        op8(OP_START, 3'd0, 8'h00);
        @(negedge clk);
        lit("abort_empty_done", 32'(bus8.tx_done), 1);
        step(2);

        // SIZE=6: address 7 is out of range
        pat = 4'b1111;
        for (int b = 3; b >= 0; b--) begin
          rx6_in = pat[b];
          step(1);
        end
        rx6_in = 1'b0;
        @(negedge clk);
        lit("s6_err", 32'(bus6.rx_err), 1);
        lit("s6_err_valid", 32'(bus6.rx_valid), 0);
        lit("s6_err_addr", 32'(bus6.rx_addr), 7);
        lit("s6_err_vec", 32'(bus6.rx_vec), 0);
        step(1);
        @(negedge clk);
        lit("s6_err_pulse", 32'(bus6.rx_err), 0);
        pat = 4'b1101;
        for (int b = 3; b >= 0; b--) begin
          rx6_in = pat[b];
          step(1);
        end
        rx6_in = 1'b0;
        @(negedge clk);
        lit("s6_valid", 32'(bus6.rx_valid), 1);
        lit("s6_addr", 32'(bus6.rx_addr), 5);
        lit("s6_vec", 32'(bus6.rx_vec), 32'(6'b100000));
        step(1);
        op6(OP_SET, 3'd7, 6'h00);
        op6(OP_START, 3'd0, 6'h00);
        @(negedge clk);
        lit("s6_set7_done", 32'(bus6.tx_done), 1);
        lit("s6_set7_bout", 32'(bus6.bitstream_out), 0);
        step(2);
        op6(OP_SET, 3'd5, 6'h00);
        op6(OP_START, 3'd0, 6'h00);
        cap4 = '0;
        for (int n = 1; n <= 4; n++) begin
          @(negedge clk);
          cap4 = {cap4[2:0], bus6.bitstream_out};
          step(1);
        end
        @(negedge clk);
        lit("s6_tx_bits", 32'(cap4), 32'(4'b1101));
        lit("s6_tx_done", 32'(bus6.tx_done), 1);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    join_any
  end

endmodule
